// File: rtl/box_blur_3x3.sv
// 3x3 box blur over an RGB pixel stream: two line buffers feed a causal 3x3 window,
// and each channel's window mean is emitted with a fixed 4-cycle latency.
`timescale 1ns/1ps
module box_blur_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        MIPI_PIXEL_CLK,
    input  logic        RESET,
    input  logic        frame_start,
    input  logic        in_valid,
    input  logic [7:0]  in_R,
    input  logic [7:0]  in_G,
    input  logic [7:0]  in_B,
    input  logic        blur_en,
    output logic        out_valid,
    output logic [7:0]  out_R,
    output logic [7:0]  out_G,
    output logic [7:0]  out_B,
    output logic [12:0] out_row,
    output logic [12:0] out_col
);

    localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [12:0] COL_LAST = 13'(IMG_W - 1);
    localparam logic [12:0] ROW_LAST = 13'(IMG_H - 1);

    logic [12:0] col, row;
    logic [12:0] cur_col, cur_row;
    logic [23:0] in_pix;

    logic [23:0] lb1 [IMG_W];
    logic [23:0] lb2 [IMG_W];
    logic [23:0] lb1_rd, lb2_rd;

    logic        s1_valid, s2_valid, s3_valid;
    logic [23:0] s1_pix, s2_pix, s3_pix;
    logic [12:0] s1_row, s1_col, s2_row, s2_col, s3_row, s3_col;

    // win[row][age][channel bits]: row 0 is the current line, age 0 the newest pixel
    logic [2:0][2:0][23:0] win;
    logic [2:0][2:0][9:0]  s3_sum;
    logic [2:0][11:0]      total;
    logic [23:0]           blurred;
    logic                  border;
    logic [23:0]           out_pix;

    // frame_start forces the coincident pixel to (0,0) before counting
    always_comb begin
        in_pix  = {in_R, in_G, in_B};
        cur_col = frame_start ? 13'd0 : col;
        cur_row = frame_start ? 13'd0 : row;
    end

    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (RESET) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? 13'd0 : cur_row + 13'd1;
            end else begin
                col <= cur_col + 13'd1;
                row <= cur_row;
            end
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end
    end

    // Read-before-write: LB1 ages into LB2 at the same column
    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (in_valid) begin
            lb1_rd              <= lb1[cur_col[AW-1:0]];
            lb2_rd              <= lb2[cur_col[AW-1:0]];
            lb1[cur_col[AW-1:0]] <= in_pix;
            lb2[cur_col[AW-1:0]] <= lb1[cur_col[AW-1:0]];
        end
    end

    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_pix <= in_pix;
                s1_row <= cur_row;
                s1_col <= cur_col;
            end
        end
    end

    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (RESET) begin
            s2_valid <= 1'b0;
            s2_pix   <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            win      <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_pix <= s1_pix;
                s2_row <= s1_row;
                s2_col <= s1_col;
                win[0] <= {win[0][1:0], s1_pix};
                win[1] <= {win[1][1:0], lb1_rd};
                win[2] <= {win[2][1:0], lb2_rd};
            end
        end
    end

    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (RESET) begin
            s3_valid <= 1'b0;
            s3_pix   <= '0;
            s3_row   <= '0;
            s3_col   <= '0;
            s3_sum   <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_pix <= s2_pix;
                s3_row <= s2_row;
                s3_col <= s2_col;
                for (int i = 0; i < 3; i++) begin
                    for (int ch = 0; ch < 3; ch++) begin
                        s3_sum[i][ch] <= 10'(win[i][0][ch*8 +: 8])
                                       + 10'(win[i][1][ch*8 +: 8])
                                       + 10'(win[i][2][ch*8 +: 8]);
                    end
                end
            end
        end
    end

    // (sum*57)>>9 approximates sum/9; the maximum 2295 lands exactly on 255
    always_comb begin
        total   = '0;
        blurred = '0;
        for (int ch = 0; ch < 3; ch++) begin
            total[ch] = 12'(s3_sum[0][ch]) + 12'(s3_sum[1][ch]) + 12'(s3_sum[2][ch]);
            blurred[ch*8 +: 8] = 8'((18'(total[ch]) * 18'd57) >> 9);
        end
        border = (s3_row < 13'd2) || (s3_col < 13'd2);
    end

    always_ff @(posedge MIPI_PIXEL_CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_pix <= (blur_en && !border) ? blurred : s3_pix;
                out_row <= s3_row;
                out_col <= s3_col;
            end
        end
    end

    assign out_R = out_pix[23:16];
    assign out_G = out_pix[15:8];
    assign out_B = out_pix[7:0];

endmodule

// File: tb/tb_box_blur_3x3.sv
// Bench for box_blur_3x3: an image-level model predicts every output pixel and its
// arrival cycle; literal spot checks pin known values from the test plan.
`timescale 1ns/1ps
module tb_box_blur_3x3;

    localparam int W = 24;
    localparam int H = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        in_valid;
    logic [7:0]  in_R, in_G, in_B;
    logic        blur_en;
    logic        out_valid;
    logic [7:0]  out_R, out_G, out_B;
    logic [12:0] out_row, out_col;

    box_blur_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .MIPI_PIXEL_CLK(clk),
        .RESET(rst),
        .frame_start(frame_start),
        .in_valid(in_valid),
        .in_R(in_R),
        .in_G(in_G),
        .in_B(in_B),
        .blur_en(blur_en),
        .out_valid(out_valid),
        .out_R(out_R),
        .out_G(out_G),
        .out_B(out_B),
        .out_row(out_row),
        .out_col(out_col)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          r;
        int          c;
        logic [23:0] pix;
    } exp_t;

    exp_t        expq[$];
    logic [23:0] img [H][W];
    logic [23:0] cap [H][W];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        checking_on = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Expected pixel straight from the image: border passthrough or 3x3 causal mean
    function automatic logic [23:0] model_pixel(input int r, input int c, input logic blur);
        logic [23:0] res;
        int          sum;
        if (!blur || r < 2 || c < 2) return img[r][c];
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    sum += int'(img[r-dr][c-dc][ch*8 +: 8]);
            res[ch*8 +: 8] = 8'((sum * 57) / 512);
        end
        return res;
    endfunction

    function automatic logic [23:0] gen_pixel(input int kind, input int val, input int r, input int c);
        logic [7:0] v8;
        case (kind)
            0: begin v8 = 8'(val); return {v8, v8, v8}; end
            1: return (r == 10 && c == 10) ? 24'hFF0000 : 24'h000000;
            2: begin v8 = 8'(c % 256); return {v8, v8, v8}; end
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic applyStimulus(input logic fs, input logic v, input int r, input int c,
                                 input logic [23:0] pix);
        exp_t e;
        @(posedge clk); #1;
        frame_start = fs;
        in_valid    = v;
        {in_R, in_G, in_B} = pix;
        if (v) begin
            img[r][c] = pix;
            e.due = cyc + 4;
            e.r   = r;
            e.c   = c;
            e.pix = model_pixel(r, c, blur_en);
            expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 24'h0);
    endtask

    // fs_mode: 0 none, 1 separate frame_start pulse, 2 frame_start on the first pixel
    task automatic send_frame(input int kind, input int val, input logic blur, input int fs_mode,
                              input int line_gap, input logic rand_gap, input int npix,
                              input int tail);
        int count = 0;
        blur_en = blur;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) cap[r][c] = 24'hFFFFFF;
        if (fs_mode == 1) applyStimulus(1'b1, 1'b0, 0, 0, 24'h0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (count < npix) begin
                    applyStimulus(fs_mode == 2 && r == 0 && c == 0, 1'b1, r, c,
                                  gen_pixel(kind, val, r, c));
                    count++;
                    if (rand_gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
            end
            if (count < npix) idle(line_gap);
        end
        idle(tail);
    endtask

    task automatic mid_frame_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset out_valid", int'(out_valid), 0);
        checkOutput("post-reset out_row", int'(out_row), 0);
        checkOutput("post-reset out_col", int'(out_col), 0);
        checkOutput("post-reset out_R", int'(out_R), 0);
    endtask

    // Every cycle: either the model says a pixel is due now, or out_valid must be low
    always @(negedge clk) begin
        if (checking_on) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                exp_t e;
                e = expq.pop_front();
                checkOutput($sformatf("out_valid(%0d,%0d)", e.r, e.c), int'(out_valid), 1);
                checkOutput($sformatf("out_row(%0d,%0d)", e.r, e.c), int'(out_row), e.r);
                checkOutput($sformatf("out_col(%0d,%0d)", e.r, e.c), int'(out_col), e.c);
                checkOutput($sformatf("pixel(%0d,%0d)", e.r, e.c), int'({out_R, out_G, out_B}),
                            int'(e.pix));
                cap[e.r][e.c] = {out_R, out_G, out_B};
            end else begin
                checkOutput("out_valid idle", int'(out_valid), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        in_valid = 1'b0;
        in_R = 8'd0; in_G = 8'd0; in_B = 8'd0;
        blur_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_R", int'(out_R), 0);
        checkOutput("reset out_G", int'(out_G), 0);
        checkOutput("reset out_B", int'(out_B), 0);
        checkOutput("reset out_row", int'(out_row), 0);
        checkOutput("reset out_col", int'(out_col), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        checking_on = 1'b1;

        send_frame(0, 100, 1'b1, 1, 0, 1'b0, W*H, 6);
        checkOutput("uniform100 (7,7)", int'(cap[7][7]), 24'h646464);
        checkOutput("uniform100 (15,23)", int'(cap[15][23]), 24'h646464);

        send_frame(0, 255, 1'b1, 2, 0, 1'b0, W*H, 6);
        checkOutput("uniform255 (8,9)", int'(cap[8][9]), 24'hFFFFFF);
        checkOutput("uniform255 (15,2)", int'(cap[15][2]), 24'hFFFFFF);

        // No frame_start: relies on the (H-1,W-1) double wrap landing on (0,0)
        send_frame(0, 0, 1'b1, 0, 0, 1'b0, W*H, 6);
        checkOutput("uniform0 (5,5)", int'(cap[5][5]), 24'h000000);

        send_frame(1, 0, 1'b1, 1, 0, 1'b0, W*H, 6);
        checkOutput("impulse (10,10)", int'(cap[10][10]), 24'h1C0000);
        checkOutput("impulse (12,12)", int'(cap[12][12]), 24'h1C0000);
        checkOutput("impulse (11,10)", int'(cap[11][10]), 24'h1C0000);
        checkOutput("impulse (9,10)", int'(cap[9][10]), 24'h000000);
        checkOutput("impulse (13,11)", int'(cap[13][11]), 24'h000000);
        checkOutput("impulse (10,13)", int'(cap[10][13]), 24'h000000);

        send_frame(2, 0, 1'b1, 1, 0, 1'b0, W*H, 6);
        checkOutput("ramp (5,20)", int'(cap[5][20]), 24'h131313);
        checkOutput("ramp border (0,5)", int'(cap[0][5]), 24'h050505);
        checkOutput("ramp border (7,1)", int'(cap[7][1]), 24'h010101);
        checkOutput("ramp border (1,22)", int'(cap[1][22]), 24'h161616);

        send_frame(3, 0, 1'b0, 1, 160, 1'b1, W*H, 6);
        send_frame(3, 0, 1'b1, 2, 3, 1'b1, W*H, 6);

        // Partial frame, then frame_start mid-line with pixels still in flight
        send_frame(3, 0, 1'b1, 1, 2, 1'b0, 3*W + 5, 0);
        send_frame(3, 0, 1'b1, 2, 2, 1'b1, W*H, 6);

        send_frame(3, 0, 1'b1, 1, 0, 1'b0, 5*W + 7, 0);
        mid_frame_reset();
        send_frame(2, 0, 1'b1, 0, 0, 1'b0, W*H, 6);
        checkOutput("post-reset ramp (1,10)", int'(cap[1][10]), 24'h0A0A0A);
        checkOutput("post-reset ramp (2,10)", int'(cap[2][10]), 24'h090909);

        idle(10);
        checkOutput("expectation queue drained", expq.size(), 0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
